serial_collector: RTL and testbench
===================================

Name: serial_collector

Overview:
- Serial-to-parallel receiver for the bit-serial datapath; the receiving end of the dual 4-bit shift-register unit's A_out/B_out streams.
- Captures two synchronous serial streams, A and B, LSB first, one bit per strobe.
- After WIDTH bits, presents both words in parallel with a one-cycle valid pulse.
- Holds the result stable for the switch/hex display path until the next capture completes.

Parameters:
- WIDTH, 4, bits per word and number of strobes per capture (must be >= 2).

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin a new capture; level-sampled.
- Bit_Valid  in  1  shift strobe; A_In/B_In are sampled on the cycle it is high.
- A_In  in  1  serial bit, stream A.
- B_In  in  1  serial bit, stream B.
- A_Word  out  WIDTH  last completed stream-A word.
- B_Word  out  WIDTH  last completed stream-B word.
- Word_Valid  out  1  one-cycle pulse when A_Word/B_Word update.
- Busy  out  1  high while in CAPTURE.
- Stray_Err  out  1  sticky flag: Bit_Valid seen outside CAPTURE.

Behaviour:
- Reset low, asynchronous:
  - State goes to IDLE.
  - Internal shift registers and bit counter are cleared.
  - A_Word = 0, B_Word = 0, Word_Valid = 0, Busy = 0, Stray_Err = 0.
- Bit order:
  - The first captured bit is bit 0 (LSB).
  - Each strobe shifts the internal register right, inserting A_In/B_In at bit WIDTH-1.
  - After WIDTH strobes, the internal register equals the transmitted word.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE:
    - Start=1 goes to CAPTURE, clears the counter and internal registers.
    - Bit_Valid in the same cycle as Start is ignored and does not set Stray_Err.
    - Bit_Valid=1 with Start=0 sets Stray_Err; no data is captured.
  - CAPTURE:
    - Busy=1.
    - Each Bit_Valid=1 cycle shifts both internal registers and increments the counter.
    - Cycles with Bit_Valid=0 hold state; gaps of any length are allowed.
    - When the WIDTH-th strobe is sampled, go to DONE.
    - Start=1 in CAPTURE restarts the capture: counter and internal registers are cleared, state stays CAPTURE, and any Bit_Valid in that cycle is ignored.
  - DONE (exactly one cycle):
    - A_Word/B_Word load the internal registers.
    - Word_Valid=1 and Busy=0.
    - Unconditionally return to IDLE.
    - Bit_Valid in DONE sets Stray_Err.
    - Start in DONE is ignored and must be reasserted in IDLE.
- Latency: Word_Valid is high the cycle after the WIDTH-th strobe is sampled. A_Word/B_Word change on the same edge that raises Word_Valid.
- Output stability: A_Word/B_Word change only on entry to DONE. They hold through subsequent IDLE/CAPTURE, including an aborted restart.
- Stray_Err: cleared only by reset, or by Start accepted in IDLE.
- Counter: ceil(log2(WIDTH+1)) bits; never wraps because DONE is forced at WIDTH.
- Reset asserted mid-CAPTURE discards the partial word and clears outputs to 0 immediately (asynchronously).

Test Plan:
- Reset, then Start, then 4 consecutive strobes with A_In=1,0,1,1 and B_In=0,0,1,0 -> one cycle after the 4th strobe: A_Word=4'hD, B_Word=4'h4, Word_Valid high exactly 1 cycle, Busy high for exactly 4 cycles.
- Same stimulus with 3 idle cycles inserted between strobes 2 and 3 -> identical words; Word_Valid one cycle after the last strobe.
- Capture 4'hF/4'hF; then Start, 2 strobes, Start again, then 4 strobes of A=0/B=1 -> words hold 4'hF/4'hF until the final DONE, then become 4'h0/4'hF; only 2 Word_Valid pulses in total.
- Bit_Valid high in IDLE -> Stray_Err=1, words unchanged; next Start -> Stray_Err=0. Start and Bit_Valid in the same cycle -> Stray_Err stays 0 and the bit is not counted.
- Reset low after 2 strobes of a capture -> A_Word=B_Word=0, Busy=0 immediately, without waiting for a clock; after release, a full capture of 4'h9/4'h6 -> correct words.
- WIDTH=8 instance: shift 8'hA5/8'h3C LSB first -> A_Word=8'hA5, B_Word=8'h3C one cycle after the 8th strobe.

Source files
------------

// File: rtl/serial_collector.sv
// Serial-to-parallel receiver for two LSB-first bit streams (A and B).
// Collects WIDTH strobed bits per stream, then presents both words with a one-cycle valid pulse.
module serial_collector #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Bit_Valid,
    input  logic             A_In,
    input  logic             B_In,
    output logic [WIDTH-1:0] A_Word,
    output logic [WIDTH-1:0] B_Word,
    output logic             Word_Valid,
    output logic             Busy,
    output logic             Stray_Err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [CW-1:0]    bit_count;
    logic             last_strobe;

    // A restart in the same cycle as a strobe wins, so that strobe never completes a word.
    assign last_strobe = (state == CAPTURE) && !Start && Bit_Valid &&
                         (bit_count == CW'(WIDTH - 1));

    assign Word_Valid = (state == DONE);
    assign Busy       = (state == CAPTURE);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (last_strobe) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Words load on the edge that enters DONE, so they change together with Word_Valid rising.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a_shift   <= '0;
            b_shift   <= '0;
            bit_count <= '0;
            A_Word    <= '0;
            B_Word    <= '0;
            Stray_Err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        a_shift   <= '0;
                        b_shift   <= '0;
                        bit_count <= '0;
                        Stray_Err <= 1'b0;
                    end else if (Bit_Valid) begin
                        Stray_Err <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (Start) begin
                        a_shift   <= '0;
                        b_shift   <= '0;
                        bit_count <= '0;
                    end else if (Bit_Valid) begin
                        a_shift   <= {A_In, a_shift[WIDTH-1:1]};
                        b_shift   <= {B_In, b_shift[WIDTH-1:1]};
                        bit_count <= bit_count + CW'(1);
                        if (last_strobe) begin
                            A_Word <= {A_In, a_shift[WIDTH-1:1]};
                            B_Word <= {B_In, b_shift[WIDTH-1:1]};
                        end
                    end
                end
                DONE: begin
                    if (Bit_Valid) begin
                        Stray_Err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_collector.sv
// Self-checking bench for serial_collector: directed test-plan steps plus randomized captures
// checked against a word-level model (last completed words and the sticky stray flag).
module tb_serial_collector;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Bit_Valid;
    logic       A_In;
    logic       B_In;

    logic [3:0] a_word4;
    logic [3:0] b_word4;
    logic       word_valid4;
    logic       busy4;
    logic       stray4;

    logic [7:0] a_word8;
    logic [7:0] b_word8;
    logic       word_valid8;
    logic       busy8;
    logic       stray8;

    int         vectors     = 0;
    int         miscompares = 0;
    int         valid_pulses = 0;
    int         busy_cycles;

    logic [3:0] model_a;
    logic [3:0] model_b;
    logic       model_stray;

    always #5 Clk = ~Clk;

    serial_collector #(.WIDTH(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Bit_Valid(Bit_Valid),
        .A_In(A_In), .B_In(B_In), .A_Word(a_word4), .B_Word(b_word4),
        .Word_Valid(word_valid4), .Busy(busy4), .Stray_Err(stray4)
    );

    serial_collector #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Bit_Valid(Bit_Valid),
        .A_In(A_In), .B_In(B_In), .A_Word(a_word8), .B_Word(b_word8),
        .Word_Valid(word_valid8), .Busy(busy8), .Stray_Err(stray8)
    );

    always @(negedge Clk) begin
        if (word_valid4 === 1'b1) valid_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs and return #1 after the rising edge that samples them.
    task automatic applyStimulus(input logic s, input logic bv, input logic a, input logic b);
        Start     = s;
        Bit_Valid = bv;
        A_In      = a;
        B_In      = b;
        @(posedge Clk);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, " a_word"}, 32'(a_word4), 32'(model_a));
        checkOutput({tag, " b_word"}, 32'(b_word4), 32'(model_b));
        checkOutput({tag, " valid"}, 32'(word_valid4), 32'd0);
        checkOutput({tag, " stray"}, 32'(stray4), 32'(model_stray));
    endtask

    // One complete 4-bit capture; gap2 idle cycles precede strobe 2, max_gap bounds random gaps.
    task automatic captureWord(input logic [3:0] a, input logic [3:0] b, input logic strobe_on_start,
                               input int gap2, input int max_gap, input string tag);
        int gap;
        busy_cycles = 0;
        applyStimulus(1'b1, strobe_on_start, 1'b1, 1'b1);
        model_stray = 1'b0;
        checkOutput({tag, " busy after start"}, 32'(busy4), 32'd1);
        checkQuiet({tag, " start"});
        for (int i = 0; i < 4; i++) begin
            if (busy4 === 1'b1) busy_cycles++;
            gap = (i == 2 && gap2 > 0) ? gap2 : (max_gap > 0 ? int'($urandom_range(0, max_gap)) : 0);
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom));
                checkOutput({tag, " busy in gap"}, 32'(busy4), 32'd1);
                checkQuiet({tag, " gap"});
            end
            applyStimulus(1'b0, 1'b1, a[i], b[i]);
        end
        model_a = a;
        model_b = b;
        checkOutput({tag, " valid"}, 32'(word_valid4), 32'd1);
        checkOutput({tag, " busy in done"}, 32'(busy4), 32'd0);
        checkOutput({tag, " a_word"}, 32'(a_word4), 32'(model_a));
        checkOutput({tag, " b_word"}, 32'(b_word4), 32'(model_b));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, " busy after done"}, 32'(busy4), 32'd0);
        checkQuiet({tag, " after done"});
    endtask

    initial begin
        logic [7:0] word8_a;
        logic [7:0] word8_b;
        int         pulses_before;

        Reset = 1'b0;
        Start = 1'b0; Bit_Valid = 1'b0; A_In = 1'b0; B_In = 1'b0;
        model_a = 4'h0; model_b = 4'h0; model_stray = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset busy", 32'(busy4), 32'd0);
        checkQuiet("reset");
        checkOutput("reset a_word8", 32'(a_word8), 32'd0);
        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back strobes: busy for exactly 4 cycles.
        captureWord(4'hD, 4'h4, 1'b0, 0, 0, "plain");
        checkOutput("plain busy cycles", 32'(busy_cycles), 32'd4);

        captureWord(4'hD, 4'h4, 1'b0, 3, 0, "gapped");

        // Restart mid-capture: old words hold, only two valid pulses in this stretch.
        pulses_before = valid_pulses;
        captureWord(4'hF, 4'hF, 1'b0, 0, 0, "allones");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkQuiet("partial");
        captureWord(4'h0, 4'hF, 1'b0, 0, 0, "restart");
        checkOutput("restart pulse count", 32'(valid_pulses - pulses_before), 32'd2);

        // Stray strobe in IDLE, cleared by the next accepted Start.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        model_stray = 1'b1;
        checkQuiet("stray idle");
        captureWord(4'h5, 4'hA, 1'b0, 0, 0, "stray clear");
        captureWord(4'h3, 4'hC, 1'b1, 0, 1, "start+strobe");

        // Asynchronous reset in the middle of a capture.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        model_a = 4'h0; model_b = 4'h0; model_stray = 1'b0;
        checkOutput("async reset busy", 32'(busy4), 32'd0);
        checkQuiet("async reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        captureWord(4'h9, 4'h6, 1'b0, 0, 0, "post reset");

        // Randomized captures with random gaps and occasional stray strobes.
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b0, 1'b1, 1'($urandom), 1'($urandom));
                model_stray = 1'b1;
                checkQuiet("random stray");
            end
            captureWord(4'($urandom), 4'($urandom), 1'($urandom), 0, 3, "random");
        end

        // WIDTH=8 instance, LSB first.
        word8_a = 8'hA5;
        word8_b = 8'h3C;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("w8 busy", 32'(busy8), 32'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, word8_a[i], word8_b[i]);
            if (i < 7) checkOutput("w8 valid early", 32'(word_valid8), 32'd0);
        end
        checkOutput("w8 valid", 32'(word_valid8), 32'd1);
        checkOutput("w8 a_word", 32'(a_word8), 32'h0000_00A5);
        checkOutput("w8 b_word", 32'(b_word8), 32'h0000_003C);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("w8 valid drop", 32'(word_valid8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
